pulse_trigger_receiver_buffered: RTL

// Next-generation front-panel trigger receiver for the 40 MHz TTC domain. Detects trigger rising edges and

---
 rtl/pulse_trigger_receiver_buffered_pkg.sv | 44 ++++
 rtl/pulse_trigger_receiver_buffered_trig_info_fifo.sv | 54 +++++
 rtl/pulse_trigger_receiver_buffered.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pulse_trigger_receiver_buffered_pkg.sv
// Shared definitions for the buffered pulse trigger receiver: state encoding,
// trigger class codes and record layout helpers.
package pulse_trigger_receiver_buffered_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CLS_W  = 2;

  localparam int unsigned ST_IDLE_BIT    = 0;
  localparam int unsigned ST_SEND_BIT    = 1;
  localparam int unsigned ST_SAMPLE_BIT  = 2;
  localparam int unsigned ST_HOLDOFF_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'(1 << ST_IDLE_BIT),
    ST_SEND    = 4'(1 << ST_SEND_BIT),
    ST_SAMPLE  = 4'(1 << ST_SAMPLE_BIT),
    ST_HOLDOFF = 4'(1 << ST_HOLDOFF_BIT)
  } state_t;

  localparam logic [CLS_W-1:0] CLS_SHORT = 2'b10;
  localparam logic [CLS_W-1:0] CLS_LONG  = 2'b01;
  localparam logic [CLS_W-1:0] CLS_MIXED = 2'b11;

  // Record layout, LSB first: timestamp, trigger number, class.
  function automatic int unsigned num_lsb(input int unsigned ts_w);
    return ts_w;
  endfunction

  function automatic int unsigned cls_lsb(input int unsigned ts_w, input int unsigned num_w);
    return ts_w + num_w;
  endfunction

  function automatic logic [CLS_W-1:0] classify(input int unsigned high,
                                                input int unsigned window,
                                                input int unsigned short_max);
    if (high <= short_max)
      return CLS_SHORT;
    else if (high == window)
      return CLS_LONG;
    else
      return CLS_MIXED;
  endfunction

endpackage

// File: rtl/pulse_trigger_receiver_buffered_trig_info_fifo.sv
// Synchronous first-word-fall-through FIFO for trigger records; push and pop
// may coincide at any occupancy, including full.
module trig_info_fifo #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = empty ? '0 : mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pulse_trigger_receiver_buffered.sv
// Front-panel trigger receiver: edge detect, one-cycle channel pulse, level
// classification over a sample window and buffered per-trigger records.
module pulse_trigger_receiver_buffered #(
  parameter int unsigned TRIG_NUM_W = 24,
  parameter int unsigned TS_W       = 44,
  parameter int unsigned WINDOW     = 4,
  parameter int unsigned SHORT_MAX  = 1,
  parameter int unsigned HOLDOFF    = 2,
  parameter int unsigned PEND_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reset_trig_num,
  input  logic         reset_trig_timestamp,
  input  logic         readout_done,
  input  logic         trigger,
  output logic         pulse_trigger,
  input  logic         fifo_ready,
  output logic         fifo_valid,
  output logic [127:0] fifo_data,
  output logic [15:0]  drop_cnt,
  output logic [3:0]   state
);

  import pulse_trigger_receiver_buffered_pkg::*;

  localparam int unsigned REC_W = CLS_W + TRIG_NUM_W + TS_W;
  localparam int unsigned CLS_LSB = cls_lsb(TS_W, TRIG_NUM_W);
  localparam int unsigned NUM_LSB = num_lsb(TS_W);
  localparam logic [3:0] LAST_SMP  = 4'(WINDOW - 1);
  localparam logic [7:0] HOLD_LAST = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

  if ((REC_W > DATA_W) || (SHORT_MAX >= WINDOW)) begin : g_bad_params
    $error("pulse_trigger_receiver_buffered: invalid parameter combination");
  end

  state_t                state_q, state_d;
  logic                  armed_q;
  logic [3:0]            smp_cnt_q;
  logic [3:0]            high_cnt_q;
  logic [7:0]            hold_cnt_q;
  logic [TRIG_NUM_W-1:0] trig_num_q;
  logic [TRIG_NUM_W-1:0] num_next;
  logic [TS_W-1:0]       ts_cnt_q;
  logic [TRIG_NUM_W-1:0] cur_num_q;
  logic [TS_W-1:0]       cur_ts_q;
  logic                  stage_valid_q;
  logic [REC_W-1:0]      stage_rec_q;
  logic [REC_W-1:0]      fifo_rec;
  logic [4:0]            high_total;
  logic                  num_clear;
  logic                  detect;
  logic                  sampling;
  logic                  last_sample;
  logic                  hold_done;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_en;

  always_comb begin
    num_clear   = reset_trig_num || readout_done;
    num_next    = num_clear ? TRIG_NUM_W'(1) : trig_num_q + 1'b1;
    detect      = (state_q == ST_IDLE) && armed_q && trigger;
    sampling    = (state_q == ST_SEND) || (state_q == ST_SAMPLE);
    last_sample = sampling && (smp_cnt_q == LAST_SMP);
    hold_done   = (hold_cnt_q == HOLD_LAST);
    high_total  = {1'b0, high_cnt_q} + {4'b0, trigger};
    pop_en      = fifo_valid && fifo_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pulse_trigger = 1'b0;
    case (state_q)
      ST_IDLE:    if (detect) state_d = ST_SEND;
      ST_SEND: begin
        pulse_trigger = 1'b1;
        state_d       = last_sample ? ST_HOLDOFF : ST_SAMPLE;
      end
      ST_SAMPLE:  if (last_sample) state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q       <= 1'b0;
      smp_cnt_q     <= '0;
      high_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      trig_num_q    <= '0;
      ts_cnt_q      <= '0;
      cur_num_q     <= '0;
      cur_ts_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_rec_q   <= '0;
      drop_cnt      <= '0;
    end else begin
      ts_cnt_q <= reset_trig_timestamp ? '0 : ts_cnt_q + 1'b1;

      if (detect)        armed_q <= 1'b0;
      else if (!trigger) armed_q <= 1'b1;

      if (detect)         trig_num_q <= num_next;
      else if (num_clear) trig_num_q <= '0;

      if (detect) begin
        cur_num_q  <= num_next;
        cur_ts_q   <= reset_trig_timestamp ? '0 : ts_cnt_q;
        smp_cnt_q  <= 4'd1;
        high_cnt_q <= 4'd1;
      end else if (sampling) begin
        smp_cnt_q  <= smp_cnt_q + 1'b1;
        high_cnt_q <= high_total[3:0];
      end

      hold_cnt_q <= (state_q == ST_HOLDOFF) ? hold_cnt_q + 1'b1 : '0;

      // Record is staged one cycle before entering the FIFO, so the word
      // surfaces at cycle WINDOW+1.
      stage_valid_q <= last_sample;
      if (last_sample)
        stage_rec_q <= {classify(int'(high_total), WINDOW, SHORT_MAX), cur_num_q, cur_ts_q};

      if (stage_valid_q && fifo_full && !pop_en && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  trig_info_fifo #(
    .WIDTH(REC_W),
    .DEPTH(PEND_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stage_valid_q),
    .push_data (stage_rec_q),
    .pop       (pop_en),
    .pop_data  (fifo_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    fifo_valid = !fifo_empty;
    fifo_data  = DATA_W'(fifo_rec);
  end

  // Field positions are fixed by the concatenation above; kept for readers.
  if (CLS_LSB != NUM_LSB + TRIG_NUM_W) begin : g_bad_layout
    $error("pulse_trigger_receiver_buffered: record layout mismatch");
  end

endmodule
